// File: rtl/seq_pattern_tx_if.sv
// Stimulus-link bundle for seq_pattern_tx: transfer request/parameters in, serial stream and status out.
// master = whoever requests transmissions, slave = the transmitter.
interface seq_pattern_tx_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             o;
  logic             o_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, repeat_n, gap,
    input  o, o_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_n, gap,
    output o, o_valid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first, with repeats and idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after every pass.
module seq_pattern_tx #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  seq_pattern_tx_if.slave   bus
);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, GAP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE} state_t;
`endif

  state_t           state, state_d;
  logic [PAT_W-1:0] pat_r, pat_d;
  logic [LEN_W-1:0] len_r, len_d;
  logic [LEN_W-1:0] bitcnt, bitcnt_d;
  logic [CNT_W-1:0] passcnt, passcnt_d;
  logic [GAP_W-1:0] gap_r, gap_d;
  logic [GAP_W-1:0] gapcnt, gapcnt_d;
  logic [LEN_W-1:0] len_c;
  logic [CNT_W-1:0] rep_c;
  logic [PAT_W-1:0] mask_c;
  logic             pass_end;

  // Clamp request fields; the pattern is stored pre-masked so parity is simply ^pat_r.
  always_comb begin
    len_c = bus.len;
    if (bus.len == '0 || bus.len > LEN_W'(PAT_W)) len_c = LEN_W'(PAT_W);
    rep_c  = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
    mask_c = (PAT_W'(1) << len_c) - PAT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pat_r   <= '0;
      len_r   <= '0;
      gap_r   <= '0;
      bitcnt  <= '0;
      passcnt <= '0;
      gapcnt  <= '0;
    end else begin
      state   <= state_d;
      pat_r   <= pat_d;
      len_r   <= len_d;
      gap_r   <= gap_d;
      bitcnt  <= bitcnt_d;
      passcnt <= passcnt_d;
      gapcnt  <= gapcnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    pat_d     = pat_r;
    len_d     = len_r;
    gap_d     = gap_r;
    bitcnt_d  = bitcnt;
    passcnt_d = passcnt;
    gapcnt_d  = gapcnt;
    pass_end  = 1'b0;

    bus.o           = 1'b0;
    bus.o_valid     = 1'b0;
    bus.frame_start = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          pat_d     = bus.pattern & mask_c;
          len_d     = len_c;
          gap_d     = bus.gap;
          bitcnt_d  = len_c - LEN_W'(1);
          passcnt_d = rep_c;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bus.o           = |(pat_r & (PAT_W'(1) << bitcnt));
        bus.o_valid     = 1'b1;
        bus.busy        = 1'b1;
        bus.frame_start = (bitcnt == len_r - LEN_W'(1));
        if (bitcnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = PARITY;
`else
          pass_end = 1'b1;
`endif
        end else begin
          bitcnt_d = bitcnt - LEN_W'(1);
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PARITY: begin
        bus.o       = ^pat_r;
        bus.o_valid = 1'b1;
        bus.busy    = 1'b1;
        pass_end    = 1'b1;
      end
`endif
      GAP: begin
        bus.busy = 1'b1;
        if (gapcnt == '0) begin
          state_d  = SHIFT;
          bitcnt_d = len_r - LEN_W'(1);
        end else begin
          gapcnt_d = gapcnt - GAP_W'(1);
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared end-of-pass routing, reached from SHIFT (no parity) or PARITY.
    if (pass_end) begin
      if (passcnt == CNT_W'(1)) begin
        state_d = DONE;
      end else begin
        passcnt_d = passcnt - CNT_W'(1);
        if (gap_r != '0) begin
          state_d  = GAP;
          gapcnt_d = gap_r - GAP_W'(1);
        end else begin
          state_d  = SHIFT;
          bitcnt_d = len_r - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a per-cycle expected-stream model.
// Honours SEQ_TX_PARITY_EN the same way as the design build.
module tb_seq_pattern_tx;
  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_pattern_tx_if #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP_W(4)) bus ();

  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {o, o_valid, frame_start, busy, done}
  logic [4:0] obs_v;
  assign obs_v = {bus.o, bus.o_valid, bus.frame_start, bus.busy, bus.done};

  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output stream from the cycle after start acceptance through the done pulse.
  function automatic void build_model(input logic [7:0] p, input logic [3:0] l,
                                      input logic [3:0] r, input logic [3:0] g);
    int   bits;
    int   passes;
    logic par;
    bits   = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    passes = (r == 4'd0) ? 1 : int'(r);
    exp_q.delete();
    for (int k = 0; k < passes; k++) begin
      par = 1'b0;
      for (int b = bits - 1; b >= 0; b--) begin
        exp_q.push_back({p[b], 1'b1, (b == bits - 1), 1'b1, 1'b0});
        par ^= p[b];
      end
`ifdef SEQ_TX_PARITY_EN
      exp_q.push_back({par, 1'b1, 1'b0, 1'b1, 1'b0});
`endif
      if (k != passes - 1)
        for (int i = 0; i < int'(g); i++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00001);
  endfunction

  task automatic run(input string name, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] r, input logic [3:0] g,
                     input bit noise, input int abort_at);
    int n;
    build_model(p, l, r, g);
    n = exp_q.size();
    bus.start    = 1'b1;
    bus.pattern  = p;
    bus.len      = l;
    bus.repeat_n = r;
    bus.gap      = g;
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", name, i), 32'(obs_v), 32'(exp_q[i]));
      if (i == abort_at) begin
        bus.start = 1'b0;
        reset     = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check({name, "_abort"}, 32'(obs_v), 32'd0);
        @(posedge clock); #1;
        check({name, "_abort_idle"}, 32'(obs_v), 32'd0);
        return;
      end
      if (noise) begin
        bus.start    = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.pattern  = 8'($urandom);
        bus.len      = 4'($urandom);
        bus.repeat_n = 4'($urandom);
        bus.gap      = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    check({name, "_idle"}, 32'(obs_v), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.pattern  = 8'hFF;
    bus.len      = 4'd4;
    bus.repeat_n = 4'd1;
    bus.gap      = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("reset[%0d]", i), 32'(obs_v), 32'd0);
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    @(posedge clock); #1;
    check("post_reset_idle", 32'(obs_v), 32'd0);

    run("basic",    8'h0D, 4'd4, 4'd1, 4'd0, 1'b0, -1);
    run("gap",      8'h05, 4'd3, 4'd2, 4'd2, 1'b0, -1);
    run("clamp0",   8'hA5, 4'd0, 4'd0, 4'd0, 1'b0, -1);
    run("clamp12",  8'h3C, 4'd12, 4'd2, 4'd0, 1'b0, -1);
    run("ignore",   8'h0D, 4'd4, 4'd1, 4'd0, 1'b1, -1);
    run("abort",    8'h0D, 4'd4, 4'd1, 4'd0, 1'b0, 2);
    run("restart",  8'h0D, 4'd4, 4'd1, 4'd0, 1'b0, -1);
    run("len1",     8'h01, 4'd1, 4'd3, 4'd0, 1'b0, -1);
    run("maxgap",   8'h96, 4'd8, 4'd2, 4'd15, 1'b0, -1);

    for (int t = 0; t < 40; t++)
      run($sformatf("rnd%0d", t), 8'($urandom), 4'($urandom), 4'($urandom_range(0, 5)),
          4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
